rx_word_aligner: RTL
====================

Name: rx_word_aligner

Overview:
- Receive-side link front end. Sits between the raw 10-bit deserializer output and the serdes decoder input (datap_i).
- Finds K28.5 comma boundaries in an unaligned bit stream, selects the bit offset and acquires lock over several commas.
- Presents aligned 10-bit words for decoding and drops link on excessive decode errors.
- Counterpart to the serdes TX framing, which inserts K28.5 idles between bursts of up to 64 data words.

Parameters:
- COMMA_N, 10'h17C, K28.5 RD- pattern, bit0 = first bit on the wire.
- COMMA_P, 10'h283, K28.5 RD+ pattern, same bit ordering.
- LOCK_CNT, 3, commas required at one offset to enter SYNC.
- ACQ_TIMEOUT, 128, valid words allowed in ACQ without a confirming comma.
- ERR_MAX, 4, error-counter value that forces loss of sync.
- GOOD_RUN, 4, consecutive error-free words that decrement the error counter.

Ports:
- clk_rx  in  1  receive clock.
- rst  in  1  reset.
- rx_raw  in  10  unaligned word from deserializer; bit0 received first.
- rx_raw_valid  in  1  rx_raw qualifier.
- code_err_i  in  1  combinational code error from decoder driven by datap_o.
- datap_o  out  10  aligned word to decoder.
- datap_valid  out  1  datap_o valid; asserted only in SYNC.
- link_up  out  1  high while in SYNC.
- align_off  out  4  current selected bit offset, 0..9.
- comma_det  out  1  one-cycle pulse when a comma is found on any offset.
- sync_lost  out  1  one-cycle pulse on SYNC->LOS.

Interface decision: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk_rx edge):
  - datap_o=10'h17C; datap_valid, link_up, comma_det, sync_lost = 0.
  - align_off=0; state=LOS; all counters 0; prev-word register 10'h17C.
  - Reset mid-operation aborts any state immediately; no output pulse.
- Window: win[19:0] = {rx_raw, prev}. Candidate at offset k is win[k+9:k], k=0..9. prev <= rx_raw on every valid cycle.
- Comma match: candidate equals COMMA_N or COMMA_P. If several offsets match, the lowest k wins.
- rx_raw_valid=0: no state, counter or prev change; datap_valid and pulses 0; datap_o holds.
- Latency: input valid at edge t produces registered outputs at edge t+1.
  - datap_o is the candidate at the align_off value held before edge t+1.
- FSM, LOS:
  - Comma at k -> ACQ, align_off<=k, lock_cnt<=1, timeout<=0.
- FSM, ACQ:
  - Comma at align_off: lock_cnt+1 and timeout<=0. If lock_cnt+1==LOCK_CNT -> SYNC.
  - Comma at a different k: restart ACQ at k, lock_cnt<=1.
  - No comma: timeout+1. If timeout+1==ACQ_TIMEOUT -> LOS, align_off held.
- FSM, SYNC:
  - datap_valid=1 per valid input. Offset frozen; commas at other offsets are ignored.
  - Error counter, on a datap_valid cycle:
    - code_err_i=1: err_cnt+1 and good_run<=0.
    - Else good_run+1. At GOOD_RUN: err_cnt-1 (saturating at 0), good_run<=0.
  - err_cnt reaching ERR_MAX: next edge -> LOS, sync_lost=1, link_up=0, counters cleared.
  - The error in the same cycle as GOOD_RUN completion wins.
- comma_det pulses in every state, one cycle after the matching input.
- Counter widths are sized from the parameters and must not wrap: timeout 8 bits at default, err_cnt 3 bits.

Decomposition:
- Shared package: K28.5 RD-/RD+ constants (also used by the serdes TX idle), FSM state encoding (LOS=0, ACQ=1, SYNC=2).
- One natural sub-module: comma_finder. Combinational; 20-bit window in, match flag and lowest-offset index out.

Test Plan:
- Reset: assert rst 2 cycles -> datap_o=10'h17C, align_off=0, link_up=0, datap_valid=0.
- Offset 0 lock: send COMMA_N, 7 data words, repeated 3x -> link_up rises one cycle after the 3rd comma, align_off=0; following data words reproduced on datap_o with datap_valid=1.
- Offset 3 lock: same stream delayed by 3 bits, alternating COMMA_N/COMMA_P -> align_off=3, datap_o equals the original words, comma_det one pulse per comma.
- ACQ handling, part 1: comma at offset 2, then a comma at offset 5 -> align_off=5 and lock restarts, needing 3 commas at 5.
- ACQ handling, part 2: a single comma then 128 comma-free words -> back to LOS, link_up stays 0.
- Error policy in SYNC:
  - code_err_i on 3 words, 4 clean words, then 2 errors -> sync_lost pulse on the 2nd error's following edge, link_up=0.
  - Variant, 4 consecutive errors -> loss of sync after the 4th.
- Reset mid-SYNC: rst pulse while streaming -> link_up=0 next edge, re-lock needs 3 fresh commas.

Source files
------------

// File: rtl/rx_word_aligner_pkg.sv
// Shared constants for the receive word aligner: K28.5 comma patterns
// (also used by the serdes TX idle generator) and the aligner FSM encoding.
package rx_word_aligner_pkg;

    // K28.5 in both running disparities, bit0 = first bit on the wire
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    // Aligner FSM encoding, kept as plain constants for legacy compatibility
    localparam logic [1:0] ST_LOS  = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;

    // Number of bit offsets searched within the two-word window
    localparam int unsigned NUM_OFFSETS = 10;

    function automatic logic is_comma(
        input logic [9:0] word,
        input logic [9:0] comma_n,
        input logic [9:0] comma_p
    );
        return (word == comma_n) || (word == comma_p);
    endfunction

endpackage

// File: rtl/rx_word_aligner_comma_finder.sv
// Combinational comma search over every bit offset of a two-word window.
// The lowest matching offset wins.
module comma_finder
    import rx_word_aligner_pkg::*;
#(
    parameter logic [9:0] COMMA_N = K28_5_RDN,
    parameter logic [9:0] COMMA_P = K28_5_RDP
) (
    // Bit 19 of the full {rx_raw, prev} window never falls inside a
    // 10-bit candidate, so only bits 18:0 are brought in.
    input  logic [18:0] win,
    output logic        match,
    output logic [3:0]  match_off
);

    // Scan offsets upward and keep the first hit
    always_comb begin
        match     = 1'b0;
        match_off = '0;
        for (int unsigned k = 0; k < NUM_OFFSETS; k++) begin
            if (!match && is_comma(win[k +: 10], COMMA_N, COMMA_P)) begin
                match     = 1'b1;
                match_off = 4'(k);
            end
        end
    end

endmodule

// File: rtl/rx_word_aligner.sv
// Receive word aligner: finds K28.5 boundaries in the raw deserializer
// stream, locks the bit offset after several commas and presents aligned
// words to the decoder, dropping sync on excessive decode errors.
module rx_word_aligner
    import rx_word_aligner_pkg::*;
#(
    parameter logic [9:0]  COMMA_N     = K28_5_RDN,
    parameter logic [9:0]  COMMA_P     = K28_5_RDP,
    parameter int unsigned LOCK_CNT    = 3,
    parameter int unsigned ACQ_TIMEOUT = 128,
    parameter int unsigned ERR_MAX     = 4,
    parameter int unsigned GOOD_RUN    = 4
) (
    input  logic       clk_rx,
    input  logic       rst,
    input  logic [9:0] rx_raw,
    input  logic       rx_raw_valid,
    input  logic       code_err_i,
    output logic [9:0] datap_o,
    output logic       datap_valid,
    output logic       link_up,
    output logic [3:0] align_off,
    output logic       comma_det,
    output logic       sync_lost
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned TO_W   = $clog2(ACQ_TIMEOUT + 1);
    localparam int unsigned ERR_W  = $clog2(ERR_MAX + 1);
    localparam int unsigned GOOD_W = $clog2(GOOD_RUN + 1);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CNT);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACQ_TIMEOUT);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_MAX);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_RUN);

    logic [1:0]        state_q,       state_d;
    logic [3:0]        align_off_q,   align_off_d;
    logic [LOCK_W-1:0] lock_cnt_q,    lock_cnt_d;
    logic [TO_W-1:0]   timeout_q,     timeout_d;
    logic [ERR_W-1:0]  err_cnt_q,     err_cnt_d;
    logic [GOOD_W-1:0] good_run_q,    good_run_d;
    logic [9:0]        prev_q,        prev_d;
    logic [9:0]        datap_o_q,     datap_o_d;
    logic              datap_valid_q, datap_valid_d;
    logic              comma_det_q,   comma_det_d;
    logic              sync_lost_q,   sync_lost_d;

    logic [18:0] win;
    logic [9:0]  cand;
    logic        match;
    logic [3:0]  match_off;
    logic        err_drop;

    // prev_q holds all of the last word, so rx_raw[9] is only needed there
    assign win = {rx_raw[8:0], prev_q};

    comma_finder #(
        .COMMA_N (COMMA_N),
        .COMMA_P (COMMA_P)
    ) u_comma_finder (
        .win       (win),
        .match     (match),
        .match_off (match_off)
    );

    // Candidate word at the currently selected offset
    always_comb begin
        cand = win[9:0];
        for (int unsigned k = 1; k < NUM_OFFSETS; k++) begin
            if (align_off_q == 4'(k)) cand = win[k +: 10];
        end
    end

    // Next-state logic: decoder error accounting, then per-word FSM
    always_comb begin
        state_d       = state_q;
        align_off_d   = align_off_q;
        lock_cnt_d    = lock_cnt_q;
        timeout_d     = timeout_q;
        err_cnt_d     = err_cnt_q;
        good_run_d    = good_run_q;
        prev_d        = prev_q;
        datap_o_d     = datap_o_q;
        datap_valid_d = 1'b0;
        comma_det_d   = 1'b0;
        sync_lost_d   = 1'b0;
        err_drop      = 1'b0;

        // code_err_i judges the word currently on datap_o, so it is
        // accounted whenever that word is valid, independent of rx_raw_valid
        if (state_q == ST_SYNC && datap_valid_q) begin
            if (code_err_i) begin
                good_run_d = '0;
                if (err_cnt_q + ERR_W'(1) == ERR_LAST) err_drop = 1'b1;
                else                                   err_cnt_d = err_cnt_q + ERR_W'(1);
            end else if (good_run_q + GOOD_W'(1) == GOOD_LAST) begin
                good_run_d = '0;
                if (err_cnt_q != '0) err_cnt_d = err_cnt_q - ERR_W'(1);
            end else begin
                good_run_d = good_run_q + GOOD_W'(1);
            end
        end

        if (err_drop) begin
            state_d     = ST_LOS;
            sync_lost_d = 1'b1;
            err_cnt_d   = '0;
            good_run_d  = '0;
            lock_cnt_d  = '0;
            timeout_d   = '0;
        end

        if (rx_raw_valid) begin
            prev_d      = rx_raw;
            datap_o_d   = cand;
            comma_det_d = match;
            case (state_q)
                ST_LOS: begin
                    if (match) begin
                        state_d     = ST_ACQ;
                        align_off_d = match_off;
                        lock_cnt_d  = LOCK_W'(1);
                        timeout_d   = '0;
                    end
                end
                ST_ACQ: begin
                    if (match && match_off == align_off_q) begin
                        timeout_d = '0;
                        if (lock_cnt_q + LOCK_W'(1) == LOCK_LAST) begin
                            state_d    = ST_SYNC;
                            lock_cnt_d = '0;
                            err_cnt_d  = '0;
                            good_run_d = '0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                        end
                    end else if (match) begin
                        align_off_d = match_off;
                        lock_cnt_d  = LOCK_W'(1);
                        timeout_d   = '0;
                    end else if (timeout_q + TO_W'(1) == TO_LAST) begin
                        state_d    = ST_LOS;
                        lock_cnt_d = '0;
                        timeout_d  = '0;
                    end else begin
                        timeout_d = timeout_q + TO_W'(1);
                    end
                end
                ST_SYNC: begin
                    // the word that triggers loss of sync is not presented
                    datap_valid_d = !err_drop;
                end
                default: begin
                    state_d = ST_LOS;
                end
            endcase
        end
    end

    // State registers with synchronous reset; prev resets to the comma, so
    // the first valid word after reset reports a comma at offset 0
    always_ff @(posedge clk_rx) begin
        if (rst) begin
            state_q       <= ST_LOS;
            align_off_q   <= '0;
            lock_cnt_q    <= '0;
            timeout_q     <= '0;
            err_cnt_q     <= '0;
            good_run_q    <= '0;
            prev_q        <= COMMA_N;
            datap_o_q     <= COMMA_N;
            datap_valid_q <= 1'b0;
            comma_det_q   <= 1'b0;
            sync_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            align_off_q   <= align_off_d;
            lock_cnt_q    <= lock_cnt_d;
            timeout_q     <= timeout_d;
            err_cnt_q     <= err_cnt_d;
            good_run_q    <= good_run_d;
            prev_q        <= prev_d;
            datap_o_q     <= datap_o_d;
            datap_valid_q <= datap_valid_d;
            comma_det_q   <= comma_det_d;
            sync_lost_q   <= sync_lost_d;
        end
    end

    assign datap_o     = datap_o_q;
    assign datap_valid = datap_valid_q;
    assign link_up     = (state_q == ST_SYNC);
    assign align_off   = align_off_q;
    assign comma_det   = comma_det_q;
    assign sync_lost   = sync_lost_q;

endmodule
